// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared state encoding, LFSR taps and seed defaults for key_bounce_gen
package key_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BOUNCE = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

    // Feedback taps for x^16 + x^14 + x^13 + x^11 + 1 (bits 15, 13, 12, 10)
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // An all-zero LFSR never leaves zero, so substitute the default seed
    function automatic logic [15:0] fix_seed(input logic [15:0] seed);
        return (seed == 16'h0000) ? DEFAULT_SEED : seed;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - free-running 16-bit Fibonacci LFSR used for random bounce gaps
module lfsr16
    import key_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] q_q;
    logic        fb;

    assign fb = ^(q_q & LFSR_TAPS);
    assign q  = q_q;

    // Shift every cycle; feedback enters at bit 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= fix_seed(seed);
        end else begin
            q_q <= {q_q[14:0], fb};
        end
    end

endmodule

// File: rtl/key_bounce_gen.sv
// rtl/key_bounce_gen.sv - bouncing key emulator; KEY_BOUNCE_RANDOM_EN selects LFSR-driven gaps
module key_bounce_gen
    import key_pkg::*;
#(
    parameter int          BOUNCE_CNT = 50,
    parameter int          GAP_W      = 16,
    parameter int          HOLD_CYC   = 1250000,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic clk,
    input  logic reset,
    input  logic cmd_valid,
    input  logic cmd_level,
    output logic cmd_ready,
    output logic key_out,
    output logic busy,
    output logic done
);

    localparam int GAP_CW = GAP_W + 1;
    localparam int TGL_W  = $clog2(BOUNCE_CNT + 1);
    localparam int HOLD_W = $clog2(HOLD_CYC + 1);

    localparam logic [TGL_W-1:0]  LAST_TGL  = TGL_W'(BOUNCE_CNT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYC);

    state_e              state_q, state_d;
    logic                key_q, key_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                rdy_q, rdy_d;
    logic                level_q, level_d;
    logic [GAP_CW-1:0]   gap_q, gap_d;
    logic [TGL_W-1:0]    tgl_q, tgl_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [GAP_CW-1:0]   gap_next;

`ifdef KEY_BOUNCE_RANDOM_EN
    logic [15:0] lfsr_q;

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .seed  (SEED),
        .q     (lfsr_q)
    );

    assign gap_next = {1'b0, lfsr_q[GAP_W-1:0]} + GAP_CW'(1);
`else
    assign gap_next = GAP_CW'(1) << GAP_W;
`endif

    assign cmd_ready = rdy_q;
    assign key_out   = key_q;
    assign busy      = busy_q;
    assign done      = done_q;

    // State and output registers; reset aborts any transition without a done pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            key_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdy_q   <= 1'b1;
            level_q <= 1'b1;
            gap_q   <= '0;
            tgl_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rdy_q   <= rdy_d;
            level_q <= level_d;
            gap_q   <= gap_d;
            tgl_q   <= tgl_d;
            hold_q  <= hold_d;
        end
    end

    // Next-state logic: outputs are computed one edge ahead so they come straight off flops
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        rdy_d   = rdy_q;
        level_d = level_q;
        gap_d   = gap_q;
        tgl_d   = tgl_q;
        hold_d  = hold_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid && rdy_q) begin
                    level_d = cmd_level;
                    busy_d  = 1'b1;
                    rdy_d   = 1'b0;
                    if (cmd_level != key_q) begin
                        state_d = ST_BOUNCE;
                        gap_d   = gap_next;
                        tgl_d   = '0;
                    end else begin
                        state_d = ST_HOLD;
                        hold_d  = HOLD_LOAD;
                    end
                end
            end

            ST_BOUNCE: begin
                if (gap_q <= GAP_CW'(1)) begin
                    tgl_d = tgl_q + TGL_W'(1);
                    if (tgl_q == LAST_TGL) begin
                        // Final edge lands on the requested level rather than blindly inverting
                        key_d   = level_q;
                        gap_d   = '0;
                        state_d = ST_HOLD;
                        hold_d  = HOLD_LOAD;
                    end else begin
                        key_d = ~key_q;
                        gap_d = gap_next;
                    end
                end else begin
                    gap_d = gap_q - GAP_CW'(1);
                end
            end

            ST_HOLD: begin
                if (hold_q <= HOLD_W'(1)) begin
                    hold_d  = '0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    rdy_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                rdy_d   = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_key_bounce_gen.sv
// tb/tb_key_bounce_gen.sv - directed self-checking bench for key_bounce_gen (BOUNCE_CNT=4, GAP_W=3, HOLD_CYC=10)
module tb_key_bounce_gen;

    localparam int N = 60;

    logic clk = 1'b0;
    logic reset;
    logic cmd_valid;
    logic cmd_level;
    logic cmd_ready;
    logic key_out;
    logic busy;
    logic done;

    int checks = 0;
    int errors = 0;

    logic key_t  [0:N];
    logic done_t [0:N];
    logic rdy_t  [0:N];
    logic busy_t [0:N];
    int   done_cnt;

    key_bounce_gen #(
        .BOUNCE_CNT (4),
        .GAP_W      (3),
        .HOLD_CYC   (10),
        .SEED       (16'hACE1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_level (cmd_level),
        .cmd_ready (cmd_ready),
        .key_out   (key_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Accept a command at edge 0, then record outputs 1 ns after each of edges 1..N.
    // pulse_at: re-assert cmd_valid across that edge; rst_at: assert reset after that edge.
    task automatic run_cmd(input logic level, input int pulse_at, input int rst_at);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_level = level;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        key_t[0] = key_out; done_t[0] = done; rdy_t[0] = cmd_ready; busy_t[0] = busy;
        done_cnt = 0;
        for (int k = 1; k <= N; k++) begin
            @(posedge clk);
            #1;
            key_t[k] = key_out; done_t[k] = done; rdy_t[k] = cmd_ready; busy_t[k] = busy;
            if (done) done_cnt++;
            cmd_valid = (k == pulse_at - 1);
            if (k == rst_at) begin
                reset = 1'b1;
                #1;
                check_eq("rst_mid_key", key_out, 1'b1);
                check_eq("rst_mid_rdy", cmd_ready, 1'b1);
                check_eq("rst_mid_busy", busy, 1'b0);
                check_eq("rst_mid_done", done, 1'b0);
            end
            if (k == rst_at + 1) reset = 1'b0;
        end
        cmd_valid = 1'b0;
    endtask

`ifndef KEY_BOUNCE_RANDOM_EN
    task automatic check_fixed_run(input string tag);
        check_eq({tag, "_busy1"}, busy_t[1], 1'b1);
        check_eq({tag, "_rdy1"}, rdy_t[1], 1'b0);
        check_eq({tag, "_key7"}, key_t[7], 1'b1);
        check_eq({tag, "_key8"}, key_t[8], 1'b0);
        check_eq({tag, "_key15"}, key_t[15], 1'b0);
        check_eq({tag, "_key16"}, key_t[16], 1'b1);
        check_eq({tag, "_key23"}, key_t[23], 1'b1);
        check_eq({tag, "_key24"}, key_t[24], 1'b0);
        check_eq({tag, "_key32"}, key_t[32], 1'b0);
        check_eq({tag, "_key41"}, key_t[41], 1'b0);
        check_eq({tag, "_done41"}, done_t[41], 1'b0);
        check_eq({tag, "_done42"}, done_t[42], 1'b1);
        check_eq({tag, "_done43"}, done_t[43], 1'b0);
        check_eq({tag, "_rdy43"}, rdy_t[43], 1'b1);
        check_eq({tag, "_busy43"}, busy_t[43], 1'b0);
        check_eq({tag, "_ndone"}, done_cnt, 1);
    endtask
`endif

`ifdef KEY_BOUNCE_RANDOM_EN
    logic ref_key [0:N];
    int   ref_done;
`endif

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_level = 1'b1;
        #1;
        check_eq("rst_key", key_out, 1'b1);
        check_eq("rst_rdy", cmd_ready, 1'b1);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Same level as key_out: straight to HOLD, done after HOLD_CYC
        run_cmd(1'b1, -10, -10);
        for (int k = 0; k <= 12; k++) check_eq("same_key", key_t[k], 1'b1);
        check_eq("same_busy1", busy_t[1], 1'b1);
        check_eq("same_done9", done_t[9], 1'b0);
        check_eq("same_done10", done_t[10], 1'b1);
        check_eq("same_rdy11", rdy_t[11], 1'b1);
        check_eq("same_ndone", done_cnt, 1);

`ifndef KEY_BOUNCE_RANDOM_EN
        // Press with fixed 8-cycle gaps
        run_cmd(1'b0, -10, -10);
        check_fixed_run("press");

        // Extra cmd_valid at +5 while bouncing must not change anything
        do_reset();
        run_cmd(1'b0, 5, -10);
        check_fixed_run("ignore");

        // Reset at +20 aborts; no done afterwards
        do_reset();
        run_cmd(1'b0, -10, 20);
        check_eq("abort_ndone", done_cnt, 0);
        check_eq("abort_key_end", key_t[N], 1'b1);
        check_eq("abort_rdy_end", rdy_t[N], 1'b1);

        // Next command after the abort behaves normally
        run_cmd(1'b0, -10, -10);
        check_fixed_run("after");
`else
        // Two runs from the same seed must match cycle for cycle
        for (int r = 0; r < 2; r++) begin
            int last;
            int nchg;
            reset = 1'b1;
            repeat (2) @(posedge clk);
            @(negedge clk);
            reset = 1'b0;
            repeat (3) @(posedge clk);
            run_cmd(1'b0, -10, -10);
            last = 0;
            nchg = 0;
            for (int k = 1; k <= N; k++) begin
                if (key_t[k] != key_t[k-1]) begin
                    check_eq("rnd_gap_lo", (k - last) >= 1, 1'b1);
                    check_eq("rnd_gap_hi", (k - last) <= 8, 1'b1);
                    last = k;
                    nchg++;
                end
            end
            check_eq("rnd_nchg", nchg, 3);
            check_eq("rnd_final", key_t[N], 1'b0);
            check_eq("rnd_ndone", done_cnt, 1);
            if (r == 0) begin
                for (int k = 0; k <= N; k++) ref_key[k] = key_t[k];
                ref_done = 0;
                for (int k = 0; k <= N; k++) if (done_t[k]) ref_done = k;
            end else begin
                int dpos;
                int diff;
                diff = 0;
                dpos = 0;
                for (int k = 0; k <= N; k++) begin
                    if (ref_key[k] != key_t[k]) diff++;
                    if (done_t[k]) dpos = k;
                end
                check_eq("rnd_repeat_key", diff, 0);
                check_eq("rnd_repeat_done", dpos, ref_done);
            end
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_bounce_gen.md
KEY_BOUNCE_GEN -- requirements
Module: key_bounce_gen

Interface
REQ-001 Parameter BOUNCE_CNT, default 50: number of key_out toggles per transition (even, at least 2).
REQ-002 Parameter GAP_W, default 16: width of the per-toggle gap field; gaps range over 1..2^GAP_W cycles.
REQ-003 Parameter HOLD_CYC, default 1250000: settle time in cycles (25 ms at 50 MHz).
REQ-004 Parameter SEED, default 16'hACE1: LFSR reset value; 0 is replaced by 16'hACE1.
REQ-005 clk  input  1  single clock, rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 cmd_valid  input  1  request a key transition.
REQ-008 cmd_level  input  1  target settled level (0 = pressed, 1 = released).
REQ-009 cmd_ready  output  1  high only in IDLE.
REQ-010 key_out  output  1  emulated bouncing key line, active-low.
REQ-011 busy  output  1  high in BOUNCE or HOLD.
REQ-012 done  output  1  one-cycle pulse when HOLD completes.

Function
REQ-013 FSM states SHALL be IDLE, BOUNCE, HOLD; all outputs registered.
REQ-014 A command SHALL be accepted on a clk edge with cmd_valid=1 and cmd_ready=1; cmd_level is latched at that edge.
REQ-015 If the latched level differs from key_out, the FSM SHALL go to BOUNCE with the gap counter loaded and toggle count 0.
REQ-016 If the latched level equals key_out, the FSM SHALL go directly to HOLD with key_out unchanged.
REQ-017 In BOUNCE the gap counter SHALL decrement every cycle.
REQ-018 On gap expiry key_out SHALL invert, the toggle count SHALL increment, and a new gap SHALL load.
REQ-019 On the BOUNCE_CNT-th toggle edge key_out SHALL be forced to the latched level instead of being inverted, and the FSM SHALL enter HOLD.
REQ-020 HOLD SHALL last exactly HOLD_CYC cycles, then pulse done for one cycle and return to IDLE.
REQ-021 done SHALL occur exactly BOUNCE_CNT*gap + HOLD_CYC cycles after the accept edge when the gap is fixed.
REQ-022 cmd_valid while busy SHALL be ignored, not queued.
REQ-023 The 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) SHALL advance every cycle regardless of state.
REQ-024 Counter widths SHALL be sized from the parameters with no wrap-around below the maximum counts.

Reset
REQ-025 While reset=1: state=IDLE, key_out=1, cmd_ready=1, busy=0, done=0, LFSR=SEED, counters=0.
REQ-026 Reset asserted mid-operation SHALL abort immediately with no done pulse.

Configuration
REQ-027 With KEY_BOUNCE_RANDOM_EN defined, each gap SHALL be lfsr[GAP_W-1:0]+1.
REQ-028 Without KEY_BOUNCE_RANDOM_EN, each gap SHALL be fixed at 2^GAP_W cycles and the LFSR SHALL not be instantiated.

Structure
REQ-029 Package key_pkg SHALL hold the state encoding, the LFSR tap constant and the default SEED.
REQ-030 Sub-module lfsr16 (clk, reset, seed, q) SHALL implement the LFSR.

Verification
All scenarios use BOUNCE_CNT=4, GAP_W=3, HOLD_CYC=10.
REQ-031 Reset pulse -> key_out=1, cmd_ready=1, busy=0, done=0.
REQ-032 Macro off, accept cmd_level=0 -> key_out sequence 0,1,0 at +8,+16,+24, forced 0 at +32, done at +42, cmd_ready=1 at +43.
REQ-033 cmd_level=1 while key_out=1 -> no toggles, done at +10.
REQ-034 cmd_valid pulsed at +5 during BOUNCE -> ignored; timing identical to REQ-032.
REQ-035 Reset at +20 -> key_out=1 and IDLE within the reset cycle, no done pulse; a following command runs normally.
REQ-036 Macro on, two runs from the same SEED -> identical toggle timing, every gap in 1..8, final key_out = cmd_level.
